// File: rtl/vecmat_psum_collector_pkg.sv
// rtl/vecmat_psum_collector_pkg.sv - shared types, saturation bounds and sizing helper for the psum collector
package vecmat_psum_collector_pkg;

   // Width of one packed lane in the vector handed to the PIM stages
   localparam int LANE_W = 16;

   // Saturation bounds of the 8-bit result
   localparam int SAT_MAX = 127;
   localparam int SAT_MIN = -128;

   // Collector FSM encoding
   typedef logic [0:0] state_t;
   localparam state_t COLLECT = 1'b0;
   localparam state_t FULL    = 1'b1;

   // Ceiling log2, used to size the lane counter
   function automatic int clogb2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/vecmat_psum_collector_if.sv
// rtl/vecmat_psum_collector_if.sv - psum input stream and packed vector output handshake bundle
interface vecmat_psum_collector_if #(
   parameter int ARRAY_DEPTH = 64,
   parameter int LANE_W      = vecmat_psum_collector_pkg::LANE_W
);
   localparam int IDX_W = vecmat_psum_collector_pkg::clogb2(ARRAY_DEPTH) + 1;

   // Per-neuron input channel
   logic                          in_valid;
   logic                          in_ready;
   logic [15:0]                   psum_x;
   logic [15:0]                   psum_h;
   logic [7:0]                    bias;
   logic                          flush;

   // Finished-vector channel
   logic                          vec_valid;
   logic                          vec_ready;
   logic [ARRAY_DEPTH*LANE_W-1:0] vec_data;
   logic [IDX_W-1:0]              idx;

   // Producer / consumer side (testbench or neighbouring stages)
   modport master (
      output in_valid, psum_x, psum_h, bias, flush, vec_ready,
      input  in_ready, vec_valid, vec_data, idx
   );

   // Collector side
   modport slave (
      input  in_valid, psum_x, psum_h, bias, flush, vec_ready,
      output in_ready, vec_valid, vec_data, idx
   );

endinterface

// File: rtl/vecmat_psum_collector_psum_sat_scale.sv
// rtl/vecmat_psum_collector_psum_sat_scale.sv - combinational psum add, bias align, rescale, saturate and lane format
module psum_sat_scale
   import vecmat_psum_collector_pkg::*;
#(
   parameter int SHIFT      = 2,
   parameter int DATA_WIDTH = 8,
   parameter int LANE_W     = vecmat_psum_collector_pkg::LANE_W
) (
   input  logic [15:0]           psum_x,
   input  logic [15:0]           psum_h,
   input  logic [DATA_WIDTH-1:0] bias,
   output logic [LANE_W-1:0]     lane,
   output logic                  clipped
);

   // 18 bits holds two full-scale psums plus a bias shifted by up to 8
   localparam logic signed [17:0] HI = 18'(SAT_MAX);
   localparam logic signed [17:0] LO = 18'(SAT_MIN);

   logic signed [17:0]    x_ext;
   logic signed [17:0]    h_ext;
   logic signed [17:0]    b_ext;
   logic signed [17:0]    b_al;
   logic signed [17:0]    sum;
   logic signed [17:0]    r;
   logic [DATA_WIDTH-1:0] r_sat;

   assign x_ext = {{2{psum_x[15]}}, psum_x};
   assign h_ext = {{2{psum_h[15]}}, psum_h};
   assign b_ext = {{(18-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};

   // Bias is aligned to the psum fixed-point scale before the common rescale
   assign b_al  = b_ext <<< SHIFT;
   assign sum   = x_ext + h_ext + b_al;
   assign r     = sum >>> SHIFT;

   // Clip the rescaled sum into the signed 8-bit range
   always_comb begin
      clipped = 1'b0;
      r_sat   = r[DATA_WIDTH-1:0];
      if (r > HI) begin
         r_sat   = HI[DATA_WIDTH-1:0];
         clipped = 1'b1;
      end else if (r < LO) begin
         r_sat   = LO[DATA_WIDTH-1:0];
         clipped = 1'b1;
      end
   end

   // PIM lane format: value in the low byte, sign extension above
   assign lane = {{(LANE_W-DATA_WIDTH){r_sat[DATA_WIDTH-1]}}, r_sat};

endmodule

// File: rtl/vecmat_psum_collector.sv
// rtl/vecmat_psum_collector.sv - collects ARRAY_DEPTH saturated neuron results into one packed vector (optional PSUM_SAT_CNT_EN clip counter)
module vecmat_psum_collector
   import vecmat_psum_collector_pkg::*;
#(
   parameter int ARRAY_DEPTH = 64,
   parameter int LANE_W      = vecmat_psum_collector_pkg::LANE_W,
   parameter int DATA_WIDTH  = 8,
   parameter int SHIFT       = 2
) (
   input  logic                clk,
   input  logic                reset,
   vecmat_psum_collector_if.slave bus
`ifdef PSUM_SAT_CNT_EN
   ,
   output logic [15:0]         sat_count
`endif
);

   localparam int IDX_W = clogb2(ARRAY_DEPTH) + 1;
   localparam int AW    = IDX_W - 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(ARRAY_DEPTH - 1);

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [LANE_W-1:0]  lanes [ARRAY_DEPTH];
   logic [LANE_W-1:0]  lane_new;
   logic               clipped;
   logic               accept;

   psum_sat_scale #(
      .SHIFT      (SHIFT),
      .DATA_WIDTH (DATA_WIDTH),
      .LANE_W     (LANE_W)
   ) u_scale (
      .psum_x  (bus.psum_x),
      .psum_h  (bus.psum_h),
      .bias    (bus.bias),
      .lane    (lane_new),
      .clipped (clipped)
   );

   // flush wins over a same-cycle input so a discarded vector never gains a lane
   assign accept        = (state == COLLECT) && bus.in_valid && !bus.flush;
   assign bus.in_ready  = (state == COLLECT);
   assign bus.vec_valid = (state == FULL);
   assign bus.idx       = idx;

   genvar g;
   generate
      for (g = 0; g < ARRAY_DEPTH; g = g + 1) begin : g_pack
         assign bus.vec_data[g*LANE_W +: LANE_W] = lanes[g];
      end
   endgenerate

   // Lane counter and COLLECT/FULL sequencing; FULL ignores flush so a finished vector survives
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= COLLECT;
         idx   <= '0;
      end else begin
         case (state)
            COLLECT: begin
               if (bus.flush) begin
                  idx <= '0;
               end else if (bus.in_valid) begin
                  idx <= idx + 1'b1;
                  if (idx == LAST) begin
                     state <= FULL;
                  end
               end
            end
            FULL: begin
               if (bus.vec_ready) begin
                  state <= COLLECT;
                  idx   <= '0;
               end
            end
            default: begin
               state <= COLLECT;
               idx   <= '0;
            end
         endcase
      end
   end

   // Lane storage; old contents persist after a handshake until overwritten
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ARRAY_DEPTH; i++) begin
            lanes[i] <= '0;
         end
      end else if (accept) begin
         lanes[idx[AW-1:0]] <= lane_new;
      end
   end

`ifdef PSUM_SAT_CNT_EN
   // Sticky count of accepted inputs that clipped, holding at all-ones
   always_ff @(posedge clk) begin
      if (reset) begin
         sat_count <= '0;
      end else if (accept && clipped && (sat_count != 16'hFFFF)) begin
         sat_count <= sat_count + 16'd1;
      end
   end
`else
   logic unused_clipped;
   assign unused_clipped = clipped;
`endif

endmodule

// File: tb/tb_vecmat_psum_collector.sv
// tb/tb_vecmat_psum_collector.sv - directed scoreboard bench for the psum collector
module tb_vecmat_psum_collector;

   localparam int AD = 64;
   localparam int LW = 16;
   localparam int DW = 8;
   localparam int SH = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vecmat_psum_collector_if #(.ARRAY_DEPTH(AD), .LANE_W(LW)) bus ();

`ifdef PSUM_SAT_CNT_EN
   logic [15:0] sat_count;
`endif

   vecmat_psum_collector #(
      .ARRAY_DEPTH (AD),
      .LANE_W      (LW),
      .DATA_WIDTH  (DW),
      .SHIFT       (SH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef PSUM_SAT_CNT_EN
      ,
      .sat_count (sat_count)
`endif
   );

   int               vectors = 0;
   int               miscompares = 0;
   logic [15:0]      sb [$];
   int               exp_sat = 0;
   logic [AD*LW-1:0] snap;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference arithmetic: returns {clipped, lane}
   function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] h, input logic [7:0] b);
      int s;
      int r;
      logic [7:0] v;
      logic c;
      s = int'($signed(x)) + int'($signed(h)) + int'($signed(b)) * (1 << SH);
      r = s >>> SH;
      c = 1'b0;
      if (r > 127) begin
         r = 127;
         c = 1'b1;
      end else if (r < -128) begin
         r = -128;
         c = 1'b1;
      end
      v = 8'(r);
      return {c, {8{v[7]}}, v};
   endfunction

   // Present one input for one cycle; expected lane is queued only if it will be accepted
   task automatic push_in(input logic [15:0] x, input logic [15:0] h, input logic [7:0] b);
      logic [16:0] m;
      bus.psum_x   = x;
      bus.psum_h   = h;
      bus.bias     = b;
      bus.in_valid = 1'b1;
      if (bus.in_ready && !bus.flush) begin
         m = model(x, h, b);
         sb.push_back(m[15:0]);
         if (m[16] && exp_sat < 65535) exp_sat++;
      end
      tick();
   endtask

   task automatic feed_rand(input int n);
      logic [15:0] x;
      logic [15:0] h;
      for (int i = 0; i < n; i++) begin
         check("valid_early", 64'(bus.vec_valid), 64'd0);
         if (i % 3 == 0) begin
            x = 16'($urandom);
            h = 16'($urandom);
         end else begin
            x = 16'(int'($urandom_range(0, 600)) - 300);
            h = 16'(int'($urandom_range(0, 600)) - 300);
         end
         push_in(x, h, 8'($urandom));
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic check_vector();
      logic [15:0] e;
      check("sb_size", 64'(sb.size()), 64'(AD));
      for (int i = 0; i < AD; i++) begin
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("lane%0d", i), 64'(bus.vec_data[i*LW +: LW]), 64'(e));
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.in_valid  = 1'b0;
      bus.psum_x    = '0;
      bus.psum_h    = '0;
      bus.bias      = '0;
      bus.flush     = 1'b0;
      bus.vec_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();

      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_vec_valid", 64'(bus.vec_valid), 64'd0);
      check("rst_idx", 64'(bus.idx), 64'd0);
      check("rst_vec_data", 64'(bus.vec_data == '0), 64'd1);
`ifdef PSUM_SAT_CNT_EN
      check("rst_sat_count", 64'(sat_count), 64'd0);
`endif

      // Directed arithmetic points
      push_in(16'd100, 16'd20, 8'd3);
      bus.in_valid = 1'b0;
      check("single_lane0", 64'(bus.vec_data[15:0]), 64'h0021);
      check("single_idx", 64'(bus.idx), 64'd1);
      push_in(16'h7FFF, 16'h7FFF, 8'd0);
      bus.in_valid = 1'b0;
      check("pos_clip", 64'(bus.vec_data[31:16]), 64'h007F);
`ifdef PSUM_SAT_CNT_EN
      check("sat_cnt_pos", 64'(sat_count), 64'd1);
`endif
      push_in(16'h8000, 16'h0000, 8'hFF);
      bus.in_valid = 1'b0;
      check("neg_clip", 64'(bus.vec_data[47:32]), 64'hFF80);
      check("neg_idx", 64'(bus.idx), 64'd3);

      // flush with a same-cycle input: input is dropped
      bus.flush = 1'b1;
      push_in(16'd1000, 16'd0, 8'd0);
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      check("flush_idx", 64'(bus.idx), 64'd0);
      check("flush_drop_lane0", 64'(bus.vec_data[15:0]), 64'h0021);
`ifdef PSUM_SAT_CNT_EN
      check("sat_cnt_flush", 64'(sat_count), 64'(exp_sat));
`endif
      sb.delete();

      // Full vector back-to-back, then backpressure
      feed_rand(AD);
      check("full_vec_valid", 64'(bus.vec_valid), 64'd1);
      check("full_in_ready", 64'(bus.in_ready), 64'd0);
      check("full_idx", 64'(bus.idx), 64'(AD));
      snap = bus.vec_data;
      for (int c = 0; c < 10; c++) begin
         bus.in_valid = 1'b1;
         bus.psum_x   = 16'($urandom);
         bus.flush    = (c == 4);
         tick();
         check("hold_stable", 64'(bus.vec_data == snap), 64'd1);
         check("hold_valid", 64'(bus.vec_valid), 64'd1);
      end
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      check_vector();
`ifdef PSUM_SAT_CNT_EN
      check("sat_cnt_vec1", 64'(sat_count), 64'(exp_sat));
`endif
      bus.vec_ready = 1'b1;
      tick();
      bus.vec_ready = 1'b0;
      check("hs_in_ready", 64'(bus.in_ready), 64'd1);
      check("hs_idx", 64'(bus.idx), 64'd0);
      check("hs_vec_valid", 64'(bus.vec_valid), 64'd0);
      check("hs_keep_data", 64'(bus.vec_data == snap), 64'd1);

      // Partial vector, stray vec_ready, flush, then a fresh vector
      feed_rand(30);
      bus.vec_ready = 1'b1;
      tick();
      bus.vec_ready = 1'b0;
      check("stray_ready_idx", 64'(bus.idx), 64'd30);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check("flush30_idx", 64'(bus.idx), 64'd0);
      sb.delete();
      feed_rand(AD);
      check("vec2_valid", 64'(bus.vec_valid), 64'd1);
      check_vector();
      bus.vec_ready = 1'b1;
      tick();
      bus.vec_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check("vec2_once", 64'(bus.vec_valid), 64'd0);
         tick();
      end
`ifdef PSUM_SAT_CNT_EN
      check("sat_cnt_vec2", 64'(sat_count), 64'(exp_sat));
`endif

      // Reset in FULL with a same-cycle vec_ready
      feed_rand(AD);
      check("vec3_valid", 64'(bus.vec_valid), 64'd1);
      reset         = 1'b1;
      bus.vec_ready = 1'b1;
      tick();
      reset         = 1'b0;
      bus.vec_ready = 1'b0;
      sb.delete();
      exp_sat = 0;
      check("rst_full_valid", 64'(bus.vec_valid), 64'd0);
      check("rst_full_data", 64'(bus.vec_data == '0), 64'd1);
      check("rst_full_idx", 64'(bus.idx), 64'd0);
      check("rst_full_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef PSUM_SAT_CNT_EN
      check("rst_full_sat", 64'(sat_count), 64'd0);
`endif
      tick();
      check("post_rst_idx", 64'(bus.idx), 64'd0);
      check("post_rst_valid", 64'(bus.vec_valid), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
